// File: rtl/core_mul.sv
// core_mul: iterative shift-add multiplier / multiply-accumulator.
// One multiplier bit is retired per cycle, so an operation is busy for W+1 cycles.
// Signed long operands are reduced to magnitudes up front.
// The product sign is applied in the single FIX cycle, together with the addend.
module core_mul #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] mul_a,
  input  logic [W-1:0] mul_b,
  input  logic [W-1:0] mul_c_hi,
  input  logic [W-1:0] mul_c_lo,
  input  logic         mul_add,
  input  logic         mul_long,
  input  logic         mul_signed,
  input  logic         mul_start,
  output logic         mul_ready,
  output logic [W-1:0] mul_q_hi,
  output logic [W-1:0] mul_q_lo
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

  state_t           state, state_next;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     a_mag, b_mag;
  logic [2*W-1:0]   prod, addend;
  logic             neg, long_op;
  logic [2*W-1:0]   signed_prod, result;
  logic             sgn_op;

  // Signed handling applies only to long operations; short results share the low word anyway.
  assign sgn_op = mul_signed & mul_long;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; a request is taken only while idle, so starts during busy are dropped.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (mul_start) begin
        accept     = 1'b1;
        state_next = MUL;
      end
      MUL:  if (cnt == CW'(W - 1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Final correction: restore the sign, then add the accumulator.
  always_comb begin
    signed_prod = neg ? (~prod + 1'b1) : prod;
    result      = signed_prod + addend;
  end

  // Datapath: latch operands on accept, shift-add per bit, publish results in FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      prod      <= '0;
      addend    <= '0;
      neg       <= 1'b0;
      long_op   <= 1'b0;
      mul_ready <= 1'b1;
      mul_q_hi  <= '0;
      mul_q_lo  <= '0;
    end else begin
      if (accept) begin
        neg       <= sgn_op & (mul_a[W-1] ^ mul_b[W-1]);
        // The magnitude of the most negative value is 2^(W-1), which still fits unsigned.
        a_mag     <= (sgn_op && mul_a[W-1]) ? (~mul_a + 1'b1) : mul_a;
        b_mag     <= (sgn_op && mul_b[W-1]) ? (~mul_b + 1'b1) : mul_b;
        prod      <= '0;
        cnt       <= '0;
        long_op   <= mul_long;
        mul_ready <= 1'b0;
        if (!mul_add)     addend <= '0;
        else if (mul_long) addend <= {mul_c_hi, mul_c_lo};
        else              addend <= {{W{1'b0}}, mul_c_lo};
      end else if (state == MUL) begin
        if (b_mag[cnt]) prod <= prod + ({{W{1'b0}}, a_mag} << cnt);
        cnt <= cnt + 1'b1;
      end else if (state == FIX) begin
        mul_q_hi  <= long_op ? result[2*W-1:W] : '0;
        mul_q_lo  <= result[W-1:0];
        mul_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_mul.sv
// tb_core_mul: scoreboard bench for core_mul (expected results queued at start, checked at ready).
module tb_core_mul;

  logic        clk;
  logic        rst;
  logic [31:0] mul_a, mul_b, mul_c_hi, mul_c_lo;
  logic        mul_add, mul_long, mul_signed, mul_start;
  logic        mul_ready;
  logic [31:0] mul_q_hi, mul_q_lo;

  int          n_tests;
  int          n_fail;
  int          cyc;
  int          t0;
  logic [63:0] exp_q[$];

  core_mul #(.W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_c_hi   (mul_c_hi),
    .mul_c_lo   (mul_c_lo),
    .mul_add    (mul_add),
    .mul_long   (mul_long),
    .mul_signed (mul_signed),
    .mul_start  (mul_start),
    .mul_ready  (mul_ready),
    .mul_q_hi   (mul_q_hi),
    .mul_q_lo   (mul_q_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, sign-extending operands for signed long.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] chi, input logic [31:0] clo,
                                        input logic add, input logic lng, input logic sgn);
    logic [63:0] aa, bb, p, ad;
    aa = (lng && sgn) ? {{32{a[31]}}, a} : {32'b0, a};
    bb = (lng && sgn) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = aa * bb;
    ad = !add ? 64'd0 : (lng ? {chi, clo} : {32'b0, clo});
    p  = p + ad;
    if (!lng) p = {32'b0, p[31:0]};
    return p;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] chi,
                       input logic [31:0] clo, input logic add, input logic lng, input logic sgn);
    mul_a = a; mul_b = b; mul_c_hi = chi; mul_c_lo = clo;
    mul_add = add; mul_long = lng; mul_signed = sgn;
  endtask

  // Issue one request at the next edge (DUT assumed ready) and queue its expected result.
  task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] chi, input logic [31:0] clo,
                          input logic add, input logic lng, input logic sgn);
    @(negedge clk);
    drive(a, b, chi, clo, add, lng, sgn);
    mul_start = 1'b1;
    exp_q.push_back(model(a, b, chi, clo, add, lng, sgn));
    @(posedge clk);
    #1;
    mul_start = 1'b0;
    t0 = cyc;
    check({tag, "_busy"}, {63'b0, mul_ready}, 64'd0);
  endtask

  // Wait (bounded) for ready, check the 33-cycle latency, pop and compare the result.
  task automatic finish_op(input string tag);
    int guard;
    logic [63:0] e;
    guard = 0;
    while (!mul_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check({tag, "_lat"}, 64'(cyc - t0), 64'd33);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check(tag, {mul_q_hi, mul_q_lo}, e);
    $display("[TB] op %s q=%h_%h exp=%h", tag, mul_q_hi, mul_q_lo, e);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] chi, input logic [31:0] clo,
                        input logic add, input logic lng, input logic sgn);
    start_op(tag, a, b, chi, clo, add, lng, sgn);
    finish_op(tag);
  endtask

  initial begin
    logic [63:0] acc;
    n_tests = 0; n_fail = 0; cyc = 0; t0 = 0;
    mul_start = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'b0, mul_ready}, 64'd1);
    check("rst_q", {mul_q_hi, mul_q_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_op("ulong_ff",   32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b1, 1'b0);
    run_op("slong_min",  32'h80000000, 32'h80000000, 0, 0, 1'b0, 1'b1, 1'b1);
    run_op("slong_m1",   32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b1, 1'b1);
    run_op("slong_mla",  32'hFFFFFFFE, 32'd3, 32'd0, 32'd10, 1'b1, 1'b1, 1'b1);
    run_op("ulong_wrap", 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
    run_op("short_mla",  32'd3, 32'd5, 32'hABCD0000, 32'd7, 1'b1, 1'b0, 1'b1);
    run_op("short_ovf",  32'h00010000, 32'h00010000, 0, 0, 1'b0, 1'b0, 1'b0);
    run_op("slong_mix",  32'h80000000, 32'd1, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1);

    // Random mix of modes.
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("rand%0d", i), $urandom, $urandom, $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Start pulsed while busy with other operands must be ignored.
    start_op("busy_ign", 32'h12345678, 32'h9ABCDEF0, 0, 0, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    drive(32'h11111111, 32'h22222222, 32'h3, 32'h4, 1'b1, 1'b1, 1'b1);
    mul_start = 1'b1;
    @(negedge clk);
    mul_start = 1'b0;
    finish_op("busy_ign");

    // Start held high: the second request is taken on the edge ready returns.
    start_op("b2b_1", 32'd1000, 32'd2000, 0, 0, 1'b0, 1'b1, 1'b0);
    drive(32'hFFFFFFF9, 32'd6, 32'd0, 32'd50, 1'b1, 1'b1, 1'b1);
    mul_start = 1'b1;
    finish_op("b2b_1");
    exp_q.push_back(model(32'hFFFFFFF9, 32'd6, 32'd0, 32'd50, 1'b1, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    mul_start = 1'b0;
    t0 = cyc;
    check("b2b_2_busy", {63'b0, mul_ready}, 64'd0);
    finish_op("b2b_2");

    // Asynchronous reset mid-MUL: immediate idle with zeroed result, no late update.
    start_op("mid_rst", 32'hCAFEBABE, 32'h0BADF00D, 0, 0, 1'b0, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_ready", {63'b0, mul_ready}, 64'd1);
    check("arst_q", {mul_q_hi, mul_q_lo}, 64'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    acc = 64'd0;
    repeat (40) begin
      @(posedge clk);
      #1;
      acc = acc | {mul_q_hi, mul_q_lo} | {63'b0, ~mul_ready};
    end
    check("arst_noupd", acc, 64'd0);

    // Unit still functional after reset.
    run_op("post_rst", 32'd7, 32'd9, 0, 0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
